// File: rtl/random_lfsr_mixer_pkg.sv
// Shared types and constants for the random LFSR mixer.
// Holds the FSM state enum, default Galois tap masks and the default seed.
package random_pkg;

    typedef enum logic {
        IDLE,
        MIX
    } state_e;

    // Maximal-length Galois right-shift feedback masks
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    localparam logic [31:0] SEED_DEFAULT_32 = 32'hFFFF_FFFF;

endpackage

// File: rtl/random_lfsr_mixer_lfsr_core.sv
// Free-running Galois LFSR with seed load and zero lock-up guard.
// Ports: clk, rst (sync, active-high), load_i/seed_i, lfsr_next_o (value after this edge).
module lfsr_core
    import random_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_32,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] lfsr_next_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // Load beats the step; an all-zero seed or state is replaced by the default
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? SEED_DEFAULT : seed_i;
        end else if (lfsr_q == '0) begin
            lfsr_d = SEED_DEFAULT;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_next_o = lfsr_d;

endmodule

// File: rtl/random_lfsr_mixer.sv
// Scramble-request front end: runs a fixed mixing window on a free LFSR and captures a word.
// Ports: clk, rst, mix_en, scramble_req, seed_load, seed -> rand_bits, rand_valid, busy, scramble_count.
module random_lfsr_mixer
    import random_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_32,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_32,
    parameter int               MIX_CYCLES   = 16,
    parameter int               CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mix_en,
    input  logic             scramble_req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] rand_bits,
    output logic             rand_valid,
    output logic             busy,
    output logic [CNT_W-1:0] scramble_count
);

    localparam int MC_W = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;
    localparam logic [MC_W-1:0] CNT_LOAD = MC_W'(MIX_CYCLES - 1);

    state_e           state_q, state_d;
    logic [MC_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] bits_q, bits_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] lfsr_next;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (seed_load),
        .seed_i      (seed),
        .lfsr_next_o (lfsr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '1;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        valid_d = 1'b0;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (scramble_req && mix_en) begin
                    state_d = MIX;
                    cnt_d   = CNT_LOAD;
                end
            end
            MIX: begin
                if (!mix_en) begin
                    // Abort leaves the last word and the count untouched
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Capture the value the LFSR takes on this very edge
                    bits_d  = lfsr_next;
                    valid_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rand_bits      = bits_q;
    assign rand_valid     = valid_q;
    assign busy           = (state_q == MIX);
    assign scramble_count = count_q;

endmodule

// File: tb/tb_random_lfsr_mixer.sv
// Self-checking bench for random_lfsr_mixer (8-bit LFSR, 4-step window, 2-bit count).
// Directed steps followed by randomized traffic against a cycle-level reference model.
module tb_random_lfsr_mixer;

    localparam int W  = 8;
    localparam int MC = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          mix_en;
    logic          scramble_req;
    logic          seed_load;
    logic [W-1:0]  seed;
    logic [W-1:0]  rand_bits;
    logic          rand_valid;
    logic          busy;
    logic [CW-1:0] scramble_count;

    int vecs = 0;
    int errs = 0;

    // Reference model: window length counted as edges remaining until capture
    int m_lfsr  = 'hFF;
    int m_bits  = 'hFF;
    int m_cnt   = 0;
    int m_rem   = 0;
    bit m_busy  = 1'b0;
    bit m_valid = 1'b0;

    int valid_seen;
    int edge_no;
    int valid_at;

    random_lfsr_mixer #(
        .WIDTH        (W),
        .TAPS         (8'hB8),
        .SEED_DEFAULT (8'hFF),
        .MIX_CYCLES   (MC),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mix_en         (mix_en),
        .scramble_req   (scramble_req),
        .seed_load      (seed_load),
        .seed           (seed),
        .rand_bits      (rand_bits),
        .rand_valid     (rand_valid),
        .busy           (busy),
        .scramble_count (scramble_count)
    );

    always #5 clk = ~clk;

    function automatic int step8(int s);
        if (s % 2 == 1) return (s / 2) ^ 'hB8;
        return s / 2;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(bit r, bit en, bit req, bit ld, logic [7:0] sd);
        int nx;
        rst          = r;
        mix_en       = en;
        scramble_req = req;
        seed_load    = ld;
        seed         = sd;
        @(posedge clk);
        edge_no++;
        if (r) nx = 'hFF;
        else if (ld) nx = (sd == 0) ? 'hFF : int'(sd);
        else if (m_lfsr == 0) nx = 'hFF;
        else nx = step8(m_lfsr);
        m_valid = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_bits = 'hFF;
            m_cnt  = 0;
            m_rem  = 0;
        end else if (m_busy) begin
            if (!en) begin
                m_busy = 1'b0;
            end else if (m_rem == 1) begin
                m_bits  = nx;
                m_valid = 1'b1;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_busy  = 1'b0;
            end else begin
                m_rem--;
            end
        end else if (req && en) begin
            m_busy = 1'b1;
            m_rem  = MC;
        end
        m_lfsr = nx;
        #1;
        chk("lfsr", 64'(dut.u_lfsr.lfsr_q), 64'(m_lfsr));
        chk("rand_bits", 64'(rand_bits), 64'(m_bits));
        chk("rand_valid", 64'(rand_valid), 64'(m_valid));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("count", 64'(scramble_count), 64'(m_cnt));
        if (rand_valid === 1'b1) begin
            valid_seen++;
            valid_at = edge_no;
        end
    endtask

    initial begin
        logic [7:0] t2_exp [4];
        int         cnt_exp [5];
        int         first_ff;
        int         pre_bits;
        int         pre_cnt;
        logic [7:0] obs;
        bit         en;
        bit         req;
        bit         ld;
        bit         r;

        t2_exp  = '{8'hB8, 8'h5C, 8'h2E, 8'h17};
        cnt_exp = '{1, 2, 3, 0, 1};
        edge_no = 0;
        valid_seen = 0;
        valid_at = 0;

        // Reset state
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        chk("rst_bits", 64'(rand_bits), 64'hFF);
        chk("rst_valid", 64'(rand_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_count", 64'(scramble_count), 64'h0);
        cyc(0, 0, 0, 0, 8'h00);

        // Seed 01 loaded on the accepting edge
        valid_seen = 0;
        cyc(0, 1, 1, 1, 8'h01);
        chk("t2_e0", 64'(dut.u_lfsr.lfsr_q), 64'h01);
        chk("t2_busy0", 64'(busy), 64'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 8'h00);
            chk("t2_seq", 64'(dut.u_lfsr.lfsr_q), 64'(t2_exp[i]));
            chk("t2_busy", 64'(busy), (i < 3) ? 64'h1 : 64'h0);
        end
        chk("t2_bits", 64'(rand_bits), 64'h17);
        chk("t2_valid", 64'(rand_valid), 64'h1);
        chk("t2_count", 64'(scramble_count), 64'h1);
        cyc(0, 1, 0, 0, 8'h00);
        chk("t2_pulses", 64'(valid_seen), 64'h1);

        // Zero seed substitutes the default; full period without lock-up
        cyc(0, 0, 0, 1, 8'h00);
        chk("t3_load", 64'(dut.u_lfsr.lfsr_q), 64'hFF);
        first_ff = 0;
        for (int i = 1; i <= 255; i++) begin
            cyc(0, 0, 0, 0, 8'h00);
            obs = dut.u_lfsr.lfsr_q;
            chk("t3_nonzero", 64'(obs != 8'h00), 64'h1);
            if (obs == 8'hFF && first_ff == 0) first_ff = i;
        end
        chk("t3_period", 64'(first_ff), 64'd255);

        // Second request two cycles into the window is ignored
        valid_seen = 0;
        cyc(0, 1, 1, 0, 8'h00);
        edge_no = 0;
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 1, (k == 2), 0, 8'h00);
        end
        chk("t4_pulses", 64'(valid_seen), 64'h1);
        chk("t4_latency", 64'(valid_at), 64'(MC));

        // mix_en dropped during the window aborts it
        valid_seen = 0;
        pre_bits = m_bits;
        pre_cnt  = m_cnt;
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        chk("t5_busy", 64'(busy), 64'h0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 8'h00);
        chk("t5_pulses", 64'(valid_seen), 64'h0);
        chk("t5_bits", 64'(rand_bits), 64'(pre_bits));
        chk("t5_count", 64'(scramble_count), 64'(pre_cnt));

        // Back-to-back scrambles wrap the 2-bit count
        cyc(1, 0, 0, 0, 8'h00);
        for (int n = 0; n < 5; n++) begin
            cyc(0, 1, 1, 0, 8'h00);
            for (int k = 0; k < MC; k++) cyc(0, 1, 0, 0, 8'h00);
            chk("t6_count", 64'(scramble_count), 64'(cnt_exp[n]));
        end

        // Reset in the middle of a window
        valid_seen = 0;
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        chk("t7_bits", 64'(rand_bits), 64'hFF);
        chk("t7_busy", 64'(busy), 64'h0);
        chk("t7_count", 64'(scramble_count), 64'h0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 8'h00);
        chk("t7_pulses", 64'(valid_seen), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 9) != 0);
            req = ($urandom_range(0, 3) == 0);
            ld  = ($urandom_range(0, 11) == 0);
            cyc(r, en, req, ld,
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
